// File: rtl/bru_pkg.sv
// Shared encodings and state type for the branch resolve unit.
// Optional statistics counters are enabled by defining BRU_STATS_EN.
package bru_pkg;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    typedef enum logic {
        S_IDLE,
        S_FLUSH
    } bru_state_t;

endpackage

// File: rtl/bru_cond_eval.sv
// Combinational MIPS branch condition evaluator.
// Reports whether the branch is taken, links, and is a legal encoding.
module bru_cond_eval
    import bru_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [5:0]        opcode_i,
    input  logic [4:0]        rt_field_i,
    input  logic [DATA_W-1:0] rs_val_i,
    input  logic [DATA_W-1:0] rt_val_i,
    output logic              cond_taken_o,
    output logic              is_link_o,
    output logic              legal_o
);

    logic eq;
    logic neg;
    logic zero;

    assign eq   = (rs_val_i == rt_val_i);
    assign neg  = rs_val_i[DATA_W-1];
    assign zero = (rs_val_i == '0);

    always_comb begin
        cond_taken_o = 1'b0;
        is_link_o    = 1'b0;
        legal_o      = 1'b1;
        case (opcode_i)
            OP_BEQ: cond_taken_o = eq;
            OP_BNE: cond_taken_o = !eq;
            OP_BLEZ: begin
                cond_taken_o = neg | zero;
                legal_o      = (rt_field_i == 5'd0);
            end
            OP_BGTZ: begin
                cond_taken_o = !neg & !zero;
                legal_o      = (rt_field_i == 5'd0);
            end
            OP_REGIMM: begin
                case (rt_field_i)
                    RT_BLTZ: cond_taken_o = neg;
                    RT_BGEZ: cond_taken_o = !neg;
                    RT_BLTZAL: begin
                        cond_taken_o = neg;
                        is_link_o    = 1'b1;
                    end
                    RT_BGEZAL: begin
                        cond_taken_o = !neg;
                        is_link_o    = 1'b1;
                    end
                    default: legal_o = 1'b0;
                endcase
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered EX-stage branch resolution with multi-cycle IF/ID flush FSM.
// Define BRU_STATS_EN to add saturating branch/taken statistics ports.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int LINK_REG     = 31
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              br_valid_i,
    input  logic              stall_i,
    input  logic [5:0]        opcode_i,
    input  logic [4:0]        rt_field_i,
    input  logic [DATA_W-1:0] rs_val_i,
    input  logic [DATA_W-1:0] rt_val_i,
    input  logic [DATA_W-1:0] pc_plus4_i,
    input  logic [DATA_W-1:0] br_target_i,
    output logic              taken_o,
    output logic [DATA_W-1:0] target_pc_o,
    output logic              link_we_o,
    output logic [4:0]        link_addr_o,
    output logic [DATA_W-1:0] link_data_o,
    output logic              if_id_reset_o,
    output logic              illegal_br_o,
    output logic              busy_o
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]       stat_branches_o,
    output logic [31:0]       stat_taken_o
`endif
);

    localparam logic [2:0] CNT_INIT =
        (FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : 3'd0;
    localparam logic FLUSH_EN = (FLUSH_CYCLES > 0);

    logic cond_taken;
    logic is_link;
    logic legal;

    bru_cond_eval #(
        .DATA_W(DATA_W)
    ) u_cond (
        .opcode_i    (opcode_i),
        .rt_field_i  (rt_field_i),
        .rs_val_i    (rs_val_i),
        .rt_val_i    (rt_val_i),
        .cond_taken_o(cond_taken),
        .is_link_o   (is_link),
        .legal_o     (legal)
    );

    bru_state_t        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              taken_q, taken_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic              link_we_q, link_we_d;
    logic [DATA_W-1:0] link_data_q, link_data_d;
    logic              illegal_q, illegal_d;

    logic accept;
    logic br_taken;

    // A branch arriving while flushing is itself a squashed instruction.
    assign accept   = br_valid_i & !stall_i & (state_q == S_IDLE);
    assign br_taken = accept & legal & cond_taken;

    always_comb begin
        taken_d     = br_taken;
        target_d    = br_taken ? br_target_i : '0;
        link_we_d   = accept & legal & is_link;
        link_data_d = (accept & legal & is_link)
                    ? pc_plus4_i + DATA_W'(4) : '0;
        illegal_d   = accept & !legal;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (br_taken && FLUSH_EN) begin
                    state_d = S_FLUSH;
                    cnt_d   = CNT_INIT;
                end
            end
            S_FLUSH: begin
                if (!stall_i) begin
                    if (cnt_q == 3'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            taken_q     <= 1'b0;
            target_q    <= '0;
            link_we_q   <= 1'b0;
            link_data_q <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            taken_q     <= taken_d;
            target_q    <= target_d;
            link_we_q   <= link_we_d;
            link_data_q <= link_data_d;
            illegal_q   <= illegal_d;
        end
    end

    assign taken_o       = taken_q;
    assign target_pc_o   = target_q;
    assign link_we_o     = link_we_q;
    assign link_addr_o   = link_we_q ? 5'(LINK_REG) : 5'd0;
    assign link_data_o   = link_data_q;
    assign illegal_br_o  = illegal_q;
    assign if_id_reset_o = (state_q == S_FLUSH);
    assign busy_o        = (state_q == S_FLUSH);

`ifdef BRU_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_tk_q, stat_tk_d;

    always_comb begin
        stat_br_d = stat_br_q;
        stat_tk_d = stat_tk_q;
        if (accept && stat_br_q != 32'hFFFF_FFFF) begin
            stat_br_d = stat_br_q + 32'd1;
        end
        if (br_taken && stat_tk_q != 32'hFFFF_FFFF) begin
            stat_tk_d = stat_tk_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stat_br_q <= 32'd0;
            stat_tk_q <= 32'd0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_tk_q <= stat_tk_d;
        end
    end

    assign stat_branches_o = stat_br_q;
    assign stat_taken_o    = stat_tk_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit at FLUSH_CYCLES = 2, 3 and 0.
// Instances share stimulus; index 0/1/2 selects FLUSH_CYCLES 2/3/0.
module tb_branch_resolve_unit;

    logic        clk;
    logic        reset;
    logic        br_valid;
    logic        stall;
    logic [5:0]  opcode;
    logic [4:0]  rt_field;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;

    logic [2:0]  taken;
    logic [31:0] target_pc [3];
    logic [2:0]  link_we;
    logic [4:0]  link_addr [3];
    logic [31:0] link_data [3];
    logic [2:0]  if_id_reset;
    logic [2:0]  illegal_br;
    logic [2:0]  busy;
`ifdef BRU_STATS_EN
    logic [31:0] stat_br [3];
    logic [31:0] stat_tk [3];
`endif

    int tests = 0;
    int fails = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        branch_resolve_unit #(
            .DATA_W      (32),
            .FLUSH_CYCLES((g == 0) ? 2 : (g == 1) ? 3 : 0),
            .LINK_REG    (31)
        ) u_dut (
            .clk_i        (clk),
            .reset_i      (reset),
            .br_valid_i   (br_valid),
            .stall_i      (stall),
            .opcode_i     (opcode),
            .rt_field_i   (rt_field),
            .rs_val_i     (rs_val),
            .rt_val_i     (rt_val),
            .pc_plus4_i   (pc_plus4),
            .br_target_i  (br_target),
            .taken_o      (taken[g]),
            .target_pc_o  (target_pc[g]),
            .link_we_o    (link_we[g]),
            .link_addr_o  (link_addr[g]),
            .link_data_o  (link_data[g]),
            .if_id_reset_o(if_id_reset[g]),
            .illegal_br_o (illegal_br[g]),
            .busy_o       (busy[g])
`ifdef BRU_STATS_EN
            ,
            .stat_branches_o(stat_br[g]),
            .stat_taken_o   (stat_tk[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic [5:0] op, input logic [4:0] rt,
                      input logic [31:0] rs, input logic [31:0] rtv);
        br_valid = 1'b1;
        opcode   = op;
        rt_field = rt;
        rs_val   = rs;
        rt_val   = rtv;
    endtask

    initial begin
        reset     = 1'b1;
        br_valid  = 1'b0;
        stall     = 1'b0;
        opcode    = 6'd0;
        rt_field  = 5'd0;
        rs_val    = 32'd0;
        rt_val    = 32'd0;
        pc_plus4  = 32'h0000_0100;
        br_target = 32'h0000_0200;
        tick();
        tick();
        chk("rst_taken", {29'd0, taken}, 32'd0);
        chk("rst_ifid", {29'd0, if_id_reset}, 32'd0);
        chk("rst_busy", {29'd0, busy}, 32'd0);
        chk("rst_target", target_pc[0], 32'd0);
        chk("rst_link", {29'd0, link_we}, 32'd0);
        reset = 1'b0;
        tick();

        // BEQ equal, taken
        br(6'b000100, 5'd0, 32'd5, 32'd5);
        tick();
        br_valid = 1'b0;
        chk("beq_taken", {29'd0, taken}, 32'd7);
        chk("beq_target", target_pc[0], 32'h200);
        chk("beq_ifid_n1", {29'd0, if_id_reset}, 32'd3);
        chk("beq_illegal", {29'd0, illegal_br}, 32'd0);
        tick();
        chk("beq_pulse_clr", {29'd0, taken}, 32'd0);
        chk("beq_ifid_n2", {29'd0, if_id_reset}, 32'd3);
        tick();
        chk("beq_ifid_n3", {29'd0, if_id_reset}, 32'd2);
        chk("beq_busy_n3", {31'd0, busy[0]}, 32'd0);
        tick();
        chk("beq_ifid_n4", {29'd0, if_id_reset}, 32'd0);

        // BNE equal, not taken
        br(6'b000101, 5'd0, 32'd7, 32'd7);
        tick();
        br_valid = 1'b0;
        chk("bne_taken", {29'd0, taken}, 32'd0);
        chk("bne_ifid", {29'd0, if_id_reset}, 32'd0);
        chk("bne_illegal", {29'd0, illegal_br}, 32'd0);

        // BLTZAL positive rs: link without branch
        br(6'b000001, 5'b10000, 32'h0000_0004, 32'd0);
        tick();
        br_valid = 1'b0;
        chk("bltzal_taken", {29'd0, taken}, 32'd0);
        chk("bltzal_we", {29'd0, link_we}, 32'd7);
        chk("bltzal_addr", {27'd0, link_addr[0]}, 32'd31);
        chk("bltzal_data", link_data[0], 32'h104);
        tick();
        chk("bltzal_we_clr", {29'd0, link_we}, 32'd0);

        // BGEZAL with negative rs, link_data wraps
        pc_plus4 = 32'hFFFF_FFFC;
        br(6'b000001, 5'b10001, 32'hFFFF_FFFF, 32'd0);
        tick();
        br_valid = 1'b0;
        chk("bgezal_neg_taken", {29'd0, taken}, 32'd0);
        chk("bgezal_neg_we", {29'd0, link_we}, 32'd7);
        chk("bgezal_wrap", link_data[1], 32'd0);
        pc_plus4 = 32'h0000_0100;

        // BAL
        br(6'b000001, 5'b10001, 32'd0, 32'd0);
        tick();
        br_valid = 1'b0;
        chk("bal_taken", {29'd0, taken}, 32'd7);
        chk("bal_we", {29'd0, link_we}, 32'd7);
        chk("bal_ds_ifid", {31'd0, if_id_reset[2]}, 32'd0);
        tick();
        tick();
        tick();
        chk("bal_drain", {29'd0, busy}, 32'd0);

        // BLEZ with illegal rt_field
        br(6'b000110, 5'd3, 32'd0, 32'd0);
        tick();
        br_valid = 1'b0;
        chk("blez_rt3_ill", {29'd0, illegal_br}, 32'd7);
        chk("blez_rt3_tk", {29'd0, taken}, 32'd0);
        tick();
        chk("blez_ill_clr", {29'd0, illegal_br}, 32'd0);

        // Jump opcode is not a conditional branch
        br(6'b000010, 5'd0, 32'd0, 32'd0);
        tick();
        br_valid = 1'b0;
        chk("op02_ill", {29'd0, illegal_br}, 32'd7);
        chk("op02_link", {29'd0, link_we}, 32'd0);

        // BGTZ zero / positive, BLTZ negative
        br(6'b000111, 5'd0, 32'd0, 32'd0);
        tick();
        br_valid = 1'b0;
        chk("bgtz_zero", {29'd0, taken}, 32'd0);
        br(6'b000001, 5'b00000, 32'h8000_0000, 32'd0);
        tick();
        br_valid = 1'b0;
        chk("bltz_neg", {29'd0, taken}, 32'd7);
        tick();
        tick();
        tick();
        chk("bltz_drain", {29'd0, busy}, 32'd0);

        // Branch under stall in IDLE is not accepted
        stall = 1'b1;
        br(6'b000100, 5'd0, 32'd1, 32'd1);
        tick();
        br_valid = 1'b0;
        stall = 1'b0;
        chk("stall_idle_tk", {29'd0, taken}, 32'd0);
        chk("stall_idle_ifid", {29'd0, if_id_reset}, 32'd0);

        // Taken BEQ then 3-cycle stall during FLUSH
        br(6'b000100, 5'd0, 32'd9, 32'd9);
        tick();
        br_valid = 1'b0;
        stall = 1'b1;
        chk("stl_n1_tk", {31'd0, taken[0]}, 32'd1);
        tick();
        chk("stl_n2_tk", {31'd0, taken[0]}, 32'd0);
        chk("stl_n2_ifid", {31'd0, if_id_reset[0]}, 32'd1);
        tick();
        chk("stl_n3_ifid", {31'd0, if_id_reset[0]}, 32'd1);
        tick();
        chk("stl_n4_ifid", {31'd0, if_id_reset[0]}, 32'd1);
        stall = 1'b0;
        tick();
        chk("stl_n5_ifid", {31'd0, if_id_reset[0]}, 32'd1);
        br(6'b000100, 5'd0, 32'd9, 32'd9);
        tick();
        br_valid = 1'b0;
        chk("busy_br_tk", {31'd0, taken[0]}, 32'd0);
        chk("busy_br_ifid", {31'd0, if_id_reset[0]}, 32'd0);
        chk("busy_br_busy", {31'd0, busy[0]}, 32'd0);
        chk("busy_br_ds_tk", {31'd0, taken[2]}, 32'd1);
        tick();
        tick();
        tick();
        chk("stl_drain", {29'd0, busy}, 32'd0);

        // Reset during FLUSH
        br(6'b000100, 5'd0, 32'd2, 32'd2);
        tick();
        br_valid = 1'b0;
        reset = 1'b1;
        chk("rmf_n1_ifid", {31'd0, if_id_reset[1]}, 32'd1);
`ifdef BRU_STATS_EN
        chk("stat_tk_pre", {31'd0, stat_tk[1] != 32'd0}, 32'd1);
`endif
        tick();
        reset = 1'b0;
        chk("rmf_n2_ifid", {31'd0, if_id_reset[1]}, 32'd0);
        chk("rmf_n2_busy", {31'd0, busy[1]}, 32'd0);
`ifdef BRU_STATS_EN
        chk("stat_tk_rst", stat_tk[1], 32'd0);
        chk("stat_br_rst", stat_br[1], 32'd0);
        br(6'b000101, 5'd0, 32'd1, 32'd2);
        tick();
        br_valid = 1'b0;
        chk("stat_tk_one", stat_tk[0], 32'd1);
        chk("stat_br_one", stat_br[0], 32'd1);
`endif
        tick();
        chk("rmf_n3_ifid", {31'd0, if_id_reset[1]}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
